// File: rtl/skin_ellipse_classifier.sv
// Streaming skin classifier: rotates (Cb', Cr') into the skin-cluster ellipse frame,
// tests the elliptical boundary and keeps saturating per-frame skin-pixel counts.
module skin_ellipse_classifier #(
  parameter int FP_W    = 18,
  parameter int FP_FRAC = 8,
  parameter int CNT_W   = 20,
  parameter int CX      = 28001,
  parameter int CY      = 38917,
  parameter int COS_T   = -209,
  parameter int SIN_T   = 147,
  parameter int ECX     = 410,
  parameter int ECY     = 617,
  parameter int INV_A2  = 26025,
  parameter int INV_B2  = 85232
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    sof,
  input  logic                    eof,
  input  logic signed [FP_W-1:0]  transcb,
  input  logic signed [FP_W-1:0]  transcr,
  output logic                    out_valid,
  output logic                    skin,
  output logic                    out_eof,
  output logic [CNT_W-1:0]        skin_count,
  output logic                    count_valid
);

  localparam int DW     = FP_W + 1;
  localparam int CW     = 10;
  localparam int PW     = DW + CW;
  localparam int SW     = PW + 1;
  localparam int EW     = SW - FP_FRAC + 1;
  localparam int QW     = 2 * EW;
  localparam int IW     = 24;
  localparam int TW     = QW + IW;
  localparam int LIM_SH = 2 * FP_FRAC + IW;

  localparam logic signed [DW-1:0] CX_S   = DW'(CX);
  localparam logic signed [DW-1:0] CY_S   = DW'(CY);
  localparam logic signed [CW-1:0] COS_S  = CW'(COS_T);
  localparam logic signed [CW-1:0] SIN_S  = CW'(SIN_T);
  localparam logic signed [CW-1:0] NSIN_S = CW'(-SIN_T);
  localparam logic signed [EW-1:0] ECX_S  = EW'(ECX);
  localparam logic signed [EW-1:0] ECY_S  = EW'(ECY);
  localparam logic [IW-1:0]        INVA_U = IW'(INV_A2);
  localparam logic [IW-1:0]        INVB_U = IW'(INV_B2);
  localparam logic [TW:0]          LIM    = {{TW{1'b0}}, 1'b1} << LIM_SH;

  logic signed [DW-1:0] dx, dy;
  logic signed [PW-1:0] p_cx, p_sy, p_nsx, p_cy;
  logic signed [SW-1:0] sum_x, sum_y;
  logic signed [EW-1:0] ex, ey;
  logic [QW-1:0]        sq_x, sq_y;
  logic [TW-1:0]        tx, ty;
  logic                 skin_r;
  logic [5:0]           v_chain, sof_chain, eof_chain;
  logic [CNT_W-1:0]     run_cnt, cnt_next;

  assign sum_x = SW'(p_cx) + SW'(p_sy);
  assign sum_y = SW'(p_nsx) + SW'(p_cy);

  // Datapath registers carry no reset: their contents only matter when the matching valid bit is set.
  always_ff @(posedge clk) begin
    dx    <= DW'(transcb) - CX_S;
    dy    <= DW'(transcr) - CY_S;
    p_cx  <= PW'(dx) * PW'(COS_S);
    p_sy  <= PW'(dy) * PW'(SIN_S);
    p_nsx <= PW'(dx) * PW'(NSIN_S);
    p_cy  <= PW'(dy) * PW'(COS_S);
    ex    <= EW'(sum_x >>> FP_FRAC) - ECX_S;
    ey    <= EW'(sum_y >>> FP_FRAC) - ECY_S;
    sq_x  <= $unsigned(QW'(ex) * QW'(ex));
    sq_y  <= $unsigned(QW'(ey) * QW'(ey));
    tx    <= TW'(sq_x) * TW'(INVA_U);
    ty    <= TW'(sq_y) * TW'(INVB_U);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skin_r    <= 1'b0;
      v_chain   <= '0;
      sof_chain <= '0;
      eof_chain <= '0;
    end else begin
      skin_r    <= ({1'b0, tx} + {1'b0, ty}) <= LIM;
      v_chain   <= {v_chain[4:0], in_valid};
      sof_chain <= {sof_chain[4:0], in_valid & sof};
      eof_chain <= {eof_chain[4:0], in_valid & eof};
    end
  end

  assign out_valid = v_chain[5];
  assign out_eof   = eof_chain[5];
  assign skin      = skin_r;

  // A sof pixel restarts the count, dropping whatever an unterminated frame left behind.
  always_comb begin
    cnt_next = run_cnt;
    if (sof_chain[5])
      cnt_next = {{(CNT_W-1){1'b0}}, skin_r};
    else if (run_cnt != {CNT_W{1'b1}})
      cnt_next = run_cnt + {{(CNT_W-1){1'b0}}, skin_r};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      skin_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (v_chain[5]) begin
        run_cnt <= cnt_next;
        if (eof_chain[5]) begin
          skin_count  <= cnt_next;
          count_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_skin_ellipse_classifier.sv
// Bench for skin_ellipse_classifier: directed table, frame sequences and random pixels
// checked every cycle against a cycle-indexed behavioural model (two counter widths).
module tb_skin_ellipse_classifier;

  localparam int MAXC    = 2048;
  localparam int CENT_CB = 28001;
  localparam int CENT_CR = 38917;

  logic clk = 1'b0;
  logic rst, in_valid, sof, eof;
  logic signed [17:0] transcb, transcr;
  logic out_valid_a, skin_a, out_eof_a, count_valid_a;
  logic out_valid_b, skin_b, out_eof_b, count_valid_b;
  logic [19:0] skin_count_a;
  logic [1:0]  skin_count_b;

  skin_ellipse_classifier #(.CNT_W(20)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eof(eof),
    .transcb(transcb), .transcr(transcr),
    .out_valid(out_valid_a), .skin(skin_a), .out_eof(out_eof_a),
    .skin_count(skin_count_a), .count_valid(count_valid_a)
  );

  skin_ellipse_classifier #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eof(eof),
    .transcb(transcb), .transcr(transcr),
    .out_valid(out_valid_b), .skin(skin_b), .out_eof(out_eof_b),
    .skin_count(skin_count_b), .count_valid(count_valid_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [17:0] cb;
    logic signed [17:0] cr;
    bit                 expSkin;
  } vec_t;

  vec_t vecs [6];

  bit h_valid [MAXC];
  bit h_sof   [MAXC];
  bit h_eof   [MAXC];
  bit h_skin  [MAXC];
  bit h_rst   [MAXC];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  longint runA = 0, runB = 0, cntA = 0, cntB = 0;
  int pulseCountA = 0;
  int outCountA = 0;

  // Ellipse membership straight from the rotation/scaling formulas in 64-bit integers.
  function automatic bit refSkin(input logic signed [17:0] cb, input logic signed [17:0] cr);
    longint dx, dy, x, y, ex, ey, tx, ty;
    dx = longint'(cb) - CENT_CB;
    dy = longint'(cr) - CENT_CR;
    x  = (-209 * dx + 147 * dy) >>> 8;
    y  = (-147 * dx - 209 * dy) >>> 8;
    ex = x - 410;
    ey = y - 617;
    tx = ex * ex * 26025;
    ty = ey * ey * 85232;
    return (tx + ty) <= (longint'(1) << 40);
  endfunction

  function automatic bit pixelLive(input int p, input int t);
    for (int s = p; s <= t; s++)
      if (h_rst[s]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOne(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model state after clock edge t, then compare both DUTs against it.
  task automatic checkOutput(input int t);
    int  p;
    bit  expV, expS, expE, expCv;
    expCv = 1'b0;
    if (h_rst[t]) begin
      runA = 0; runB = 0; cntA = 0; cntB = 0;
    end else begin
      p = t - 6;
      if (p >= 0 && h_valid[p] && pixelLive(p, t - 1)) begin
        if (h_sof[p]) begin
          runA = h_skin[p];
          runB = h_skin[p];
        end else begin
          runA = (runA + h_skin[p] > 1048575) ? 1048575 : runA + h_skin[p];
          runB = (runB + h_skin[p] > 3) ? 3 : runB + h_skin[p];
        end
        if (h_eof[p]) begin
          cntA  = runA;
          cntB  = runB;
          expCv = 1'b1;
        end
      end
    end
    p = t - 5;
    expV = 1'b0; expS = 1'b0; expE = 1'b0;
    if (!h_rst[t] && p >= 0 && h_valid[p] && pixelLive(p, t)) begin
      expV = 1'b1;
      expS = h_skin[p];
      expE = h_eof[p];
    end
    if (h_rst[t]) checkOne("skin_in_reset", longint'(skin_a), 0);
    checkOne("out_valid_a", longint'(out_valid_a), longint'(expV));
    checkOne("out_valid_b", longint'(out_valid_b), longint'(expV));
    if (expV) begin
      checkOne("skin_a", longint'(skin_a), longint'(expS));
      checkOne("skin_b", longint'(skin_b), longint'(expS));
    end
    checkOne("out_eof_a", longint'(out_eof_a), longint'(expE));
    checkOne("count_valid_a", longint'(count_valid_a), longint'(expCv));
    checkOne("count_valid_b", longint'(count_valid_b), longint'(expCv));
    checkOne("skin_count_a", longint'(skin_count_a), cntA);
    checkOne("skin_count_b", longint'(skin_count_b), cntB);
    if (count_valid_a) pulseCountA++;
    if (out_valid_a) outCountA++;
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge sample them, then check.
  task automatic applyStimulus(input bit v, input bit s, input bit e,
                               input logic signed [17:0] cb, input logic signed [17:0] cr,
                               input bit expSkin, input bit r);
    if (cyc >= MAXC) begin
      $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    rst = r; in_valid = v; sof = s; eof = e; transcb = cb; transcr = cr;
    h_valid[cyc] = v; h_sof[cyc] = s; h_eof[cyc] = e; h_skin[cyc] = expSkin; h_rst[cyc] = r;
    @(posedge clk);
    @(negedge clk);
    checkOutput(cyc);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 18'sd0, 18'sd0, 1'b0, 1'b0);
  endtask

  task automatic centrePix(input bit s, input bit e);
    applyStimulus(1'b1, s, e, 18'(CENT_CB), 18'(CENT_CR), 1'b1, 1'b0);
  endtask

  task automatic farPix(input bit s, input bit e);
    applyStimulus(1'b1, s, e, 18'sd0, 18'sd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic signed [17:0] rcb, rcr;
    bit rv, rs, re, rr;

    vecs[0] = '{cb: 18'(CENT_CB),        cr: 18'(CENT_CR),  expSkin: 1'b1};
    vecs[1] = '{cb: 18'sd0,              cr: 18'sd0,        expSkin: 1'b0};
    vecs[2] = '{cb: 18'(CENT_CB + 2560), cr: 18'(CENT_CR),  expSkin: 1'b1};
    vecs[3] = '{cb: 18'(CENT_CB + 5120), cr: 18'(CENT_CR),  expSkin: 1'b0};
    vecs[4] = '{cb: -18'sd131072,        cr: 18'sd131071,   expSkin: 1'b0};
    vecs[5] = '{cb: 18'sd131071,         cr: -18'sd131072,  expSkin: 1'b0};

    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; eof = 1'b0; transcb = '0; transcr = '0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 18'sd0, 18'sd0, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, vecs[i].cb, vecs[i].cr, vecs[i].expSkin, 1'b0);
    idle(8);

    centrePix(1'b1, 1'b0);
    centrePix(1'b0, 1'b0);
    farPix(1'b0, 1'b0);
    centrePix(1'b0, 1'b1);
    idle(8);
    checkOne("frame4_count", longint'(skin_count_a), 3);

    pulseCountA = 0;
    centrePix(1'b1, 1'b0);
    idle(1);
    centrePix(1'b0, 1'b1);
    farPix(1'b1, 1'b1);
    idle(8);
    checkOne("bubble_pulses", longint'(pulseCountA), 2);
    checkOne("single_pixel_count", longint'(skin_count_a), 0);

    centrePix(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) centrePix(1'b0, 1'b0);
    centrePix(1'b0, 1'b1);
    idle(8);
    checkOne("sat_count_b", longint'(skin_count_b), 3);
    checkOne("wide_count_a", longint'(skin_count_a), 5);

    outCountA = 0;
    centrePix(1'b1, 1'b0);
    centrePix(1'b0, 1'b0);
    centrePix(1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'sd0, 18'sd0, 1'b0, 1'b1);
    idle(8);
    checkOne("reset_drop_outs", longint'(outCountA), 0);
    checkOne("reset_count", longint'(skin_count_a), 0);
    centrePix(1'b1, 1'b0);
    farPix(1'b0, 1'b0);
    centrePix(1'b0, 1'b1);
    idle(8);
    checkOne("post_reset_count", longint'(skin_count_a), 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        rcb = 18'($urandom());
        rcr = 18'($urandom());
      end else begin
        rcb = 18'(CENT_CB + int'($urandom_range(0, 12000)) - 6000);
        rcr = 18'(CENT_CR + int'($urandom_range(0, 10000)) - 5000);
      end
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 9) == 0);
      re = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 199) == 0);
      applyStimulus(rv, rs, re, rcb, rcr, refSkin(rcb, rcr), rr);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/skin_ellipse_classifier.md
# skin_ellipse_classifier

Downstream consumer of the per-channel nonlinear chroma transform stages (transformed Cb' and Cr'). Each valid pixel is rotated into the skin-cluster ellipse frame and tested against the elliptical boundary, producing a 1-bit skin decision. Per-frame skin-pixel counts are accumulated from frame markers. The pipeline is fully streaming, accepts one pixel per clock and has no backpressure.

## Interface
- FP_W, 18: width of the signed fixed-point inputs, Q10.8.
- FP_FRAC, 8: fractional bits of the inputs.
- CNT_W, 20: width of the skin counter. The counter saturates.
- CX, 28001: ellipse centre on the Cb' axis, 109.38 in Q.8.
- CY, 38917: ellipse centre on the Cr' axis, 152.02 in Q.8.
- COS_T, -209: cos(2.53) in signed Q.8.
- SIN_T, 147: sin(2.53) in signed Q.8.
- ECX, 410: ellipse offset in x, 1.60 in Q.8.
- ECY, 617: ellipse offset in y, 2.41 in Q.8.
- INV_A2, 26025: 1/25.39² in unsigned Q0.24.
- INV_B2, 85232: 1/14.03² in unsigned Q0.24.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the input pixel is valid this cycle.
- sof  in  1  first pixel of a frame. Qualified by in_valid.
- eof  in  1  last pixel of a frame. Qualified by in_valid.
- transcb  in  FP_W  signed Cb', Q10.8.
- transcr  in  FP_W  signed Cr', Q10.8.
- out_valid  out  1  skin is valid this cycle.
- skin  out  1  1 = pixel lies inside or on the ellipse.
- out_eof  out  1  eof delayed to align with out_valid.
- skin_count  out  CNT_W  skin-pixel count of the last completed frame.
- count_valid  out  1  one-cycle pulse when skin_count updates.

## Operation
- S1: register dx = transcb − CX and dy = transcr − CY, each FP_W+1 bits signed.
- S2: form the four products COS_T·dx, SIN_T·dy, −SIN_T·dx and COS_T·dy at full precision, Q.16.
- S3:
  - x = (COS_T·dx + SIN_T·dy) >>> 8, arithmetic shift, floor.
  - y = (−SIN_T·dx + COS_T·dy) >>> 8, arithmetic shift, floor.
  - Register ex = x − ECX and ey = y − ECY.
- S4: register ex² and ey², unsigned, Q.16.
- S5: register tx = ex²·INV_A2 and ty = ey²·INV_B2, Q.40.
- S6:
  - skin = (tx + ty ≤ 2^40). The comparison is inclusive.
  - All internal widths are full precision, so no intermediate overflows for any FP_W input.
- in_valid, sof and eof travel down a 6-deep valid/marker shift chain alongside the data.
- Invalid cycles are bubbles. Data registers may hold garbage while their valid bit is 0.
- Frame accumulator, acting on output-side pixels where out_valid=1:
  - sof pixel: running count = skin, which discards any unterminated previous count.
  - Non-sof pixel: running count += skin, saturating at 2^CNT_W − 1.
  - eof pixel: the final count, including that pixel, loads into skin_count and count_valid pulses on the next cycle.
  - sof and eof on the same pixel: a one-pixel frame. skin_count becomes 0 or 1.
  - Pixels outside any frame still accumulate into the running count. The next sof clears them.
- Reset values:
  - out_valid, skin, out_eof, count_valid = 0.
  - skin_count = 0.
  - Running count = 0.
  - All valid-chain bits = 0.
- Reset mid-operation drops every in-flight pixel. No out_valid is produced for pixels accepted before or during the reset cycle.

## Timing
- Latency is 6 cycles. A pixel with in_valid at edge N gives out_valid, skin and out_eof at edge N+6.
- Throughput is 1 pixel/clk, with no stalls.
- count_valid asserts at edge N+7 for an eof pixel accepted at N, for one cycle. skin_count is stable from that edge until the next update.
- Back-to-back frames: if eof is followed immediately by sof, both counts are handled correctly. A count_valid pulse may coincide with the new frame's first out_valid.
- rst is sampled on clk. Outputs are at reset values on the edge after rst=1 and stay there while rst is held.

## Test plan
- Centre pixel: transcb=28001, transcr=38917 → tx+ty ≈ 3.68e10 ≤ 2^40, so skin=1 with out_valid exactly 6 cycles after in_valid.
- Far pixel: transcb=0, transcr=0 → x=513, y=47850, skin=0.
- 4-pixel frame of centre, centre, far, centre with sof on pixel 0 and eof on pixel 3 → skin_count=3 and a single count_valid pulse at the input edge of pixel 3 plus 7.
- Bubbles, back-to-back frames and a single-pixel frame:
  - Alternate in_valid 1/0 across a frame of 2 centre pixels, then immediately a sof+eof far pixel.
  - Required: counts 2 then 0, the out_valid pattern matches the input pattern delayed by 6, and two count_valid pulses.
- Saturation: CNT_W=2 with a frame of 5 centre pixels → skin_count=3.
- Reset mid-pipeline: feed 3 valid pixels, assert rst for 1 cycle two cycles later → none of those pixels produce out_valid, and all outputs are 0. The next frame counts normally.
